// File: rtl/vector_packer.sv
// -----------------------------------------------------------------------------
// vector_packer
//   Packs RATIO narrow IN_W-bit slices from a valid/ready stream into one
//   registered OUT_W = IN_W*RATIO bit word. The slice order is selectable. A
//   flush request emits a partially filled word, with the unfilled slots zero.
//
// Parameters
//   IN_W      slice width in bits (>= 1)
//   RATIO     slices per output word (>= 2)
//   MSB_FIRST 1: the first slice lands in the top slot; 0: it lands in the bottom slot
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_data     input slice
//   in_valid    slice present
//   in_ready    packer accepts a slice this cycle
//   flush       single-cycle request to emit the partial word
//   out_data    packed word, with unfilled slots zero
//   out_valid   word present
//   out_ready   consumer accepts the word
//   out_fill    number of valid slices in out_data
//   out_partial word was produced by a flush with out_fill < RATIO
// -----------------------------------------------------------------------------
module vector_packer #(
  parameter int IN_W      = 4,
  parameter int RATIO     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [IN_W*RATIO-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(RATIO+1)-1:0]   out_fill,
  output logic                         out_partial
);

  localparam int OUT_W  = IN_W * RATIO;
  localparam int CNT_W  = $clog2(RATIO);
  localparam int FILL_W = $clog2(RATIO + 1);
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(RATIO - 1);
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(RATIO);

  // Returns the LSB position of slot k, which depends on the chosen slice order.
  function automatic int slot_lsb(input int k);
    return (MSB_FIRST != 0) ? (RATIO - 1 - k) * IN_W : k * IN_W;
  endfunction

  logic [OUT_W-1:0]  r_asm;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_flush_pend;
  logic [OUT_W-1:0]  r_out_data;
  logic              r_out_valid;
  logic [FILL_W-1:0] r_out_fill;
  logic              r_out_partial;

  logic              w_slot_free;
  logic              w_in_ready;
  logic              w_acc;
  logic              w_complete;
  logic              w_flush_req;
  logic              w_flush_emit;
  logic [FILL_W-1:0] w_fill_eff;
  logic [OUT_W-1:0]  w_asm_ld;

  assign w_slot_free = !r_out_valid || out_ready;
  // The last slot may be accepted only when the completed word has somewhere to go.
  assign w_in_ready  = !r_flush_pend && ((r_cnt != LAST_SLOT) || w_slot_free);
  assign w_acc       = in_valid && w_in_ready;
  assign w_complete  = w_acc && (r_cnt == LAST_SLOT);

  // The fill count includes a slice accepted in the same cycle, so a
  // flush that arrives together with a slice still packs that slice.
  assign w_fill_eff  = FILL_W'(r_cnt) + FILL_W'(w_acc);

  // A new flush request is handled together with any pending one, so a
  // repeated flush never emits a second word.
  assign w_flush_req  = flush || r_flush_pend;
  assign w_flush_emit = w_flush_req && w_slot_free && !w_complete &&
                        (w_fill_eff != '0);

  // The assembly register with the current slice merged into its slot.
  always_comb begin
    w_asm_ld = r_asm;
    for (int k = 0; k < RATIO; k++) begin
      if (w_acc && (r_cnt == CNT_W'(k))) begin
        w_asm_ld[slot_lsb(k) +: IN_W] = in_data;
      end
    end
  end

  // Assembly state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      if (w_complete || w_flush_emit) begin
        r_asm <= '0;
        r_cnt <= '0;
      end else if (w_acc) begin
        r_asm <= w_asm_ld;
        r_cnt <= r_cnt + 1'b1;
      end
      // A flush waits only while the output slot is occupied.
      r_flush_pend <= w_flush_req && !w_slot_free;
    end
  end

  // Output word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_fill    <= '0;
      r_out_partial <= 1'b0;
    end else begin
      if (w_complete) begin
        r_out_data    <= w_asm_ld;
        r_out_valid   <= 1'b1;
        r_out_fill    <= FULL_FILL;
        r_out_partial <= 1'b0;
      end else if (w_flush_emit) begin
        r_out_data    <= w_asm_ld;
        r_out_valid   <= 1'b1;
        r_out_fill    <= w_fill_eff;
        r_out_partial <= 1'b1;
      end else if (out_ready) begin
        // Data, fill and partial keep the last word for observability.
        r_out_valid   <= 1'b0;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_fill    = r_out_fill;
  assign out_partial = r_out_partial;

endmodule

// File: tb/tb_vector_packer.sv
module tb_vector_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: IN_W=4, RATIO=2, MSB_FIRST=1
  logic [3:0] a_d = '0;
  logic       a_v = 1'b0, a_fl = 1'b0, a_or = 1'b1;
  logic       a_ir, a_ov, a_part;
  logic [7:0] a_od;
  logic [1:0] a_fill;

  // Instance B: IN_W=4, RATIO=2, MSB_FIRST=0
  logic [3:0] b_d = '0;
  logic       b_v = 1'b0, b_fl = 1'b0, b_or = 1'b1;
  logic       b_ir, b_ov, b_part;
  logic [7:0] b_od;
  logic [1:0] b_fill;

  // Instance C: IN_W=8, RATIO=4, MSB_FIRST=1
  logic [7:0]  c_d = '0;
  logic        c_v = 1'b0, c_fl = 1'b0, c_or = 1'b1;
  logic        c_ir, c_ov, c_part;
  logic [31:0] c_od;
  logic [2:0]  c_fill;

  vector_packer #(.IN_W(4), .RATIO(2), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_d), .in_valid(a_v), .in_ready(a_ir),
    .flush(a_fl), .out_data(a_od), .out_valid(a_ov), .out_ready(a_or),
    .out_fill(a_fill), .out_partial(a_part));

  vector_packer #(.IN_W(4), .RATIO(2), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_d), .in_valid(b_v), .in_ready(b_ir),
    .flush(b_fl), .out_data(b_od), .out_valid(b_ov), .out_ready(b_or),
    .out_fill(b_fill), .out_partial(b_part));

  vector_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_d), .in_valid(c_v), .in_ready(c_ir),
    .flush(c_fl), .out_data(c_od), .out_valid(c_ov), .out_ready(c_or),
    .out_fill(c_fill), .out_partial(c_part));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step(); step();
    check("rst_ov", a_ov, 0);
    check("rst_od", a_od, 0);
    check("rst_fill", a_fill, 0);
    check("rst_part", a_part, 0);
    rst_n = 1'b1;
    #1 check("rst_ir", a_ir, 1);

    // Back-to-back 0xA,0x5 on A (MSB first) and B (LSB first)
    a_d = 4'hA; a_v = 1; b_d = 4'hA; b_v = 1;
    step();
    check("a_no_word_yet", a_ov, 0);
    a_d = 4'h5; b_d = 4'h5;
    step();
    a_v = 0; b_v = 0;
    check("a_ov", a_ov, 1);
    check("a_word", a_od, 32'hA5);
    check("a_fill", a_fill, 2);
    check("a_part", a_part, 0);
    check("b_word", b_od, 32'h5A);
    check("b_ov", b_ov, 1);
    step();
    check("a_drain", a_ov, 0);

    // C: 0x11,0x22,0x33,0x44 -> 0x11223344
    c_v = 1;
    c_d = 8'h11; step();
    c_d = 8'h22; step();
    c_d = 8'h33; step();
    check("c_no_word_yet", c_ov, 0);
    c_d = 8'h44; step();
    c_v = 0;
    check("c_word", c_od, 32'h11223344);
    check("c_fill", c_fill, 4);
    check("c_ov", c_ov, 1);

    // Back-pressure: 0x1,0x2,0x3,0x4 with out_ready low
    a_or = 0;
    a_d = 4'h1; a_v = 1;
    #1 check("bp_ir_1", a_ir, 1);
    step();
    a_d = 4'h2;
    #1 check("bp_ir_2", a_ir, 1);
    step();
    a_d = 4'h3;
    #1 check("bp_ir_3", a_ir, 1);
    check("bp_word12", a_od, 32'h12);
    check("bp_ov12", a_ov, 1);
    step();
    a_d = 4'h4;
    #1 check("bp_ir_4_blocked", a_ir, 0);
    step();
    check("bp_hold_od", a_od, 32'h12);
    check("bp_hold_ov", a_ov, 1);
    check("bp_still_blocked", a_ir, 0);
    step();
    check("bp_hold_od2", a_od, 32'h12);
    a_or = 1;
    #1 check("bp_ir_release", a_ir, 1);
    step();
    a_v = 0;
    check("bp_word34", a_od, 32'h34);
    check("bp_ov34", a_ov, 1);
    check("bp_fill34", a_fill, 2);
    step();
    check("bp_drain", a_ov, 0);

    // Partial flush: 0xE then flush -> 0xE0
    a_d = 4'hE; a_v = 1; step();
    a_v = 0; a_fl = 1; step();
    a_fl = 0;
    check("fl_word", a_od, 32'hE0);
    check("fl_fill", a_fill, 1);
    check("fl_part", a_part, 1);
    check("fl_ov", a_ov, 1);
    step();
    check("fl_drain", a_ov, 0);

    // Flush with nothing assembled: no word
    a_fl = 1; step();
    a_fl = 0;
    check("fl0_no_word", a_ov, 0);
    check("fl0_ir", a_ir, 1);
    step();
    check("fl0_no_word_later", a_ov, 0);

    // Flush coinciding with the completing slice: one full word only
    a_d = 4'h3; a_v = 1; step();
    a_d = 4'h7; a_fl = 1; step();
    a_v = 0; a_fl = 0;
    check("flc_word", a_od, 32'h37);
    check("flc_part", a_part, 0);
    check("flc_fill", a_fill, 2);
    step();
    check("flc_no_second", a_ov, 0);
    step();
    check("flc_no_second_later", a_ov, 0);

    // Flush while the output slot is busy waits for the slot
    a_or = 0;
    a_d = 4'h1; a_v = 1; step();
    a_d = 4'h2; step();
    a_d = 4'h9; step();
    a_v = 0; a_fl = 1; step();
    a_fl = 0;
    check("flp_hold_word", a_od, 32'h12);
    check("flp_ir_blocked", a_ir, 0);
    step();
    check("flp_still_held", a_od, 32'h12);
    a_or = 1; step();
    check("flp_word", a_od, 32'h90);
    check("flp_part", a_part, 1);
    check("flp_fill", a_fill, 1);
    check("flp_ir", a_ir, 1);
    step();
    check("flp_drain", a_ov, 0);

    // Reset mid-word with a held output word
    a_or = 0;
    a_d = 4'hA; a_v = 1; step();
    a_d = 4'hB; step();
    a_d = 4'h6; step();
    a_v = 0;
    check("mr_pre_ov", a_ov, 1);
    rst_n = 0;
    #1;
    check("mr_ov", a_ov, 0);
    check("mr_od", a_od, 0);
    check("mr_fill", a_fill, 0);
    check("mr_part", a_part, 0);
    step();
    rst_n = 1; a_or = 1;
    a_d = 4'h9; a_v = 1; step();
    a_d = 4'hC; step();
    a_v = 0;
    check("mr_word", a_od, 32'h9C);
    check("mr_fill_after", a_fill, 2);
    check("mr_ov_after", a_ov, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vector_packer.md
# vector_packer

Parametrised slice-to-word packer: accepts narrow IN_W-bit slices over a valid/ready stream and concatenates RATIO of them into one registered OUT_W-bit word. It is the sequential, handshaked generalisation of our fixed-width `{x[3:0], y[3:0]}` concatenation logic, with selectable slice order and partial-word flush. It sits between narrow producers (nibble/byte sources) and wide consumers (register files, bus writers).

## Interface
- IN_W, 4, slice width in bits (>=1)
- RATIO, 2, slices per output word (>=2); OUT_W = IN_W*RATIO
- MSB_FIRST, 1, 1: first slice lands in out_data[OUT_W-1 -: IN_W]; 0: first slice lands in out_data[IN_W-1:0]
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  IN_W  input slice
- in_valid  in  1  slice present
- in_ready  out  1  packer accepts slice this cycle
- flush  in  1  single-cycle request: emit partial word
- out_data  out  OUT_W  packed word, unfilled slices zero
- out_valid  out  1  word present
- out_ready  in  1  consumer accepts word
- out_fill  out  clog2(RATIO+1)  number of valid slices in out_data (RATIO when full)
- out_partial  out  1  word produced by flush with out_fill < RATIO

## Operation
- State: assembly register asm (OUT_W), slice counter cnt (0..RATIO-1), flush_pend, output register set (out_data/out_valid/out_fill/out_partial).
- Slice accept: in_valid && in_ready. Slice k (k = cnt) written to asm slot k (MSB_FIRST=1: bits [OUT_W-1-k*IN_W -: IN_W]; else [k*IN_W +: IN_W]); other slots unchanged.
- Slot free: slot_free = !out_valid || out_ready.
- in_ready = !flush_pend && (cnt != RATIO-1 || slot_free). Combinational from out_ready; no other in->out comb paths.
- Completion: accept with cnt == RATIO-1 -> out_data <= asm with slot loaded, out_fill <= RATIO, out_partial <= 0, out_valid <= 1; cnt <= 0; asm <= 0.
- Output drain: out_valid && out_ready with no new word -> out_valid <= 0; out_data/out_fill/out_partial hold last value.
- Flush: flush=1 sets flush_pend (same-cycle accepted slice is included first). While flush_pend and slot_free: if cnt (including any same-cycle slice) > 0, emit asm as word with out_fill = cnt, out_partial = 1, cnt <= 0, asm <= 0; if cnt == 0, no word. flush_pend clears in that cycle.
- Flush coinciding with completing slice: full word emitted (out_partial=0), flush_pend clears with no extra word.
- flush while flush_pend=1: no effect (no double emit).
- Counter wraps RATIO-1 -> 0 only via completion or flush.

## Timing
- Reset (async assert, sync-to-clk deassert by upstream): out_valid=0, out_data=0, out_fill=0, out_partial=0, cnt=0, asm=0, flush_pend=0; in_ready=1 after reset.
- Latency: completing slice accepted at edge N -> out_valid=1 after edge N; visible cycle N+1.
- Throughput: one slice per cycle sustained while out_ready=1; one word per RATIO cycles.
- Back-pressure: with out_valid=1 and out_ready=0, in_ready stays 1 until cnt == RATIO-1, then 0 until out_ready=1.
- Flush latency: 1 cycle when slot free; otherwise word emitted on first cycle slot_free=1.
- Reset mid-word or mid-flush discards asm, cnt, flush_pend and any held output word.
- out_data stable while out_valid && !out_ready.

## Test plan
- IN_W=4, RATIO=2, MSB_FIRST=1: slices 0xA,0x5 back-to-back, out_ready=1 -> one word 0xA5, out_fill=2, out_partial=0, one cycle after second accept.
- Same, MSB_FIRST=0 -> 0x5A; IN_W=8, RATIO=4, slices 0x11,0x22,0x33,0x44 MSB_FIRST=1 -> 0x11223344.
- out_ready=0, stream 0x1,0x2,0x3,0x4 -> word 0x12 held stable, in_ready=1 for 0x3, in_ready=0 at 0x4 until out_ready=1; then 0x34 follows; no slice lost.
- Slice 0xE then flush -> 0xE0, out_fill=1, out_partial=1; flush with cnt=0 -> no word, in_ready returns 1 next cycle.
- Flush same cycle as second slice 0x7 after 0x3 -> single word 0x37, out_partial=0, no second word.
- Assert rst_n=0 after one slice and with out_valid=1 -> outputs zero immediately; next slices 0x9,0xC -> 0x9C.
